// File: rtl/alu_issue_station.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_station                                             |
// | Purpose  : Collapsing age-ordered reservation station feeding one ALU;   |
// |            operands wake up from the CDB, oldest ready entry issues.     |
// | Options  : ALU_ISSUE_BYPASS_EN - a CDB-matched operand is selectable in  |
// |            the same cycle it is broadcast.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_issue_station #(
    parameter int  DATA_WIDTH = 64,
    parameter int  DEPTH      = 4,
    parameter int  TAG_WIDTH  = 4,
    parameter type operation_specification = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  operation_specification in_op_spec,
    input  logic [DATA_WIDTH-1:0]  in_lhs,
    input  logic [DATA_WIDTH-1:0]  in_rhs,
    input  logic                   in_lhs_valid,
    input  logic                   in_rhs_valid,
    input  logic [TAG_WIDTH-1:0]   in_lhs_tag,
    input  logic [TAG_WIDTH-1:0]   in_rhs_tag,
    input  logic [TAG_WIDTH-1:0]   in_dst_tag,
    input  logic                   cdb_valid,
    input  logic [TAG_WIDTH-1:0]   cdb_tag,
    input  logic [DATA_WIDTH-1:0]  cdb_data,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [DATA_WIDTH-1:0]  alu_lhs,
    output logic [DATA_WIDTH-1:0]  alu_rhs,
    output logic                   alu_lhs_valid,
    output logic                   alu_rhs_valid,
    output operation_specification alu_op_spec,
    output logic [TAG_WIDTH-1:0]   alu_dst_tag
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0]        count_q, count_d, w_cnt_after;
    logic [DEPTH-1:0]        lhs_v_q, lhs_v_d, rhs_v_q, rhs_v_d;
    logic [DATA_WIDTH-1:0]   lhs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   lhs_d [DEPTH];
    logic [DATA_WIDTH-1:0]   rhs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rhs_d [DEPTH];
    logic [TAG_WIDTH-1:0]    lhs_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]    lhs_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]    rhs_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]    rhs_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]    dst_q [DEPTH];
    logic [TAG_WIDTH-1:0]    dst_d [DEPTH];
    operation_specification  op_q [DEPTH];
    operation_specification  op_d [DEPTH];

    logic                    issue_valid_q, issue_valid_d;
    logic [DATA_WIDTH-1:0]   alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;
    operation_specification  alu_op_q, alu_op_d;
    logic [TAG_WIDTH-1:0]    alu_dst_q, alu_dst_d;

    logic [DEPTH-1:0]        w_lhs_v, w_rhs_v, w_elig;
    logic [DATA_WIDTH-1:0]   w_lhs [DEPTH];
    logic [DATA_WIDTH-1:0]   w_rhs [DEPTH];
    logic                    w_new_lhs_v, w_new_rhs_v, w_new_elig;
    logic [DATA_WIDTH-1:0]   w_new_lhs, w_new_rhs;
    logic                    w_found, w_load, w_alloc;
    logic                    w_take_held, w_take_new, w_store_new;
    logic [IDX_W-1:0]        w_sel;

    assign in_ready      = (count_q < CNT_W'(DEPTH));
    assign issue_valid   = issue_valid_q;
    assign alu_lhs_valid = issue_valid_q;
    assign alu_rhs_valid = issue_valid_q;
    assign alu_lhs       = alu_lhs_q;
    assign alu_rhs       = alu_rhs_q;
    assign alu_op_spec   = alu_op_q;
    assign alu_dst_tag   = alu_dst_q;

    // CDB wakeup of held entries and of the operation being allocated.
    always_comb begin
        w_lhs_v = '0;
        w_rhs_v = '0;
        w_elig  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_lhs_v[i] = lhs_v_q[i] | (cdb_valid && (lhs_tag_q[i] == cdb_tag));
            w_rhs_v[i] = rhs_v_q[i] | (cdb_valid && (rhs_tag_q[i] == cdb_tag));
            w_lhs[i]   = lhs_v_q[i] ? lhs_q[i] : (w_lhs_v[i] ? cdb_data : lhs_q[i]);
            w_rhs[i]   = rhs_v_q[i] ? rhs_q[i] : (w_rhs_v[i] ? cdb_data : rhs_q[i]);
`ifdef ALU_ISSUE_BYPASS_EN
            w_elig[i]  = (i < int'(count_q)) && w_lhs_v[i] && w_rhs_v[i];
`else
            w_elig[i]  = (i < int'(count_q)) && lhs_v_q[i] && rhs_v_q[i];
`endif
        end
        w_new_lhs_v = in_lhs_valid | (cdb_valid && (in_lhs_tag == cdb_tag));
        w_new_rhs_v = in_rhs_valid | (cdb_valid && (in_rhs_tag == cdb_tag));
        w_new_lhs   = in_lhs_valid ? in_lhs : cdb_data;
        w_new_rhs   = in_rhs_valid ? in_rhs : cdb_data;
`ifdef ALU_ISSUE_BYPASS_EN
        w_new_elig  = w_new_lhs_v & w_new_rhs_v;
`else
        w_new_elig  = in_lhs_valid & in_rhs_valid;
`endif
    end

    // Oldest ready held entry wins; the incoming op only issues directly when none is ready.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
        w_load      = ~issue_valid_q | issue_ready;
        w_alloc     = in_valid & in_ready & ~flush;
        w_take_held = w_load & w_found;
        w_take_new  = w_load & ~w_found & w_alloc & w_new_elig;
        w_store_new = w_alloc & ~w_take_new;
    end

    always_comb begin
        lhs_d     = w_lhs;
        rhs_d     = w_rhs;
        lhs_v_d   = w_lhs_v;
        rhs_v_d   = w_rhs_v;
        lhs_tag_d = lhs_tag_q;
        rhs_tag_d = rhs_tag_q;
        dst_d     = dst_q;
        op_d      = op_q;

        if (w_take_held) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                if (j >= int'(w_sel)) begin
                    lhs_d[j]     = w_lhs[j+1];
                    rhs_d[j]     = w_rhs[j+1];
                    lhs_v_d[j]   = w_lhs_v[j+1];
                    rhs_v_d[j]   = w_rhs_v[j+1];
                    lhs_tag_d[j] = lhs_tag_q[j+1];
                    rhs_tag_d[j] = rhs_tag_q[j+1];
                    dst_d[j]     = dst_q[j+1];
                    op_d[j]      = op_q[j+1];
                end
            end
        end

        w_cnt_after = count_q - CNT_W'(w_take_held);
        if (w_store_new) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == int'(w_cnt_after)) begin
                    lhs_d[j]     = w_new_lhs;
                    rhs_d[j]     = w_new_rhs;
                    lhs_v_d[j]   = w_new_lhs_v;
                    rhs_v_d[j]   = w_new_rhs_v;
                    lhs_tag_d[j] = in_lhs_tag;
                    rhs_tag_d[j] = in_rhs_tag;
                    dst_d[j]     = in_dst_tag;
                    op_d[j]      = in_op_spec;
                end
            end
        end
        count_d = w_cnt_after + CNT_W'(w_store_new);

        issue_valid_d = issue_valid_q;
        alu_lhs_d     = alu_lhs_q;
        alu_rhs_d     = alu_rhs_q;
        alu_op_d      = alu_op_q;
        alu_dst_d     = alu_dst_q;
        if (w_load) begin
            issue_valid_d = w_take_held | w_take_new;
            if (w_take_held) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(w_sel)) begin
                        alu_lhs_d = w_lhs[i];
                        alu_rhs_d = w_rhs[i];
                        alu_op_d  = op_q[i];
                        alu_dst_d = dst_q[i];
                    end
                end
            end else if (w_take_new) begin
                alu_lhs_d = w_new_lhs;
                alu_rhs_d = w_new_rhs;
                alu_op_d  = in_op_spec;
                alu_dst_d = in_dst_tag;
            end
        end

        if (flush) begin
            count_d       = '0;
            lhs_v_d       = '0;
            rhs_v_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            lhs_v_q       <= '0;
            rhs_v_q       <= '0;
            issue_valid_q <= 1'b0;
            alu_lhs_q     <= '0;
            alu_rhs_q     <= '0;
            alu_op_q      <= '0;
            alu_dst_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lhs_q[i]     <= '0;
                rhs_q[i]     <= '0;
                lhs_tag_q[i] <= '0;
                rhs_tag_q[i] <= '0;
                dst_q[i]     <= '0;
                op_q[i]      <= '0;
            end
        end else begin
            count_q       <= count_d;
            lhs_v_q       <= lhs_v_d;
            rhs_v_q       <= rhs_v_d;
            issue_valid_q <= issue_valid_d;
            alu_lhs_q     <= alu_lhs_d;
            alu_rhs_q     <= alu_rhs_d;
            alu_op_q      <= alu_op_d;
            alu_dst_q     <= alu_dst_d;
            lhs_q         <= lhs_d;
            rhs_q         <= rhs_d;
            lhs_tag_q     <= lhs_tag_d;
            rhs_tag_q     <= rhs_tag_d;
            dst_q         <= dst_d;
            op_q          <= op_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_station.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_issue_station                                          |
// | Purpose  : Directed bench for alu_issue_station with a queue-based       |
// |            reference model (honours ALU_ISSUE_BYPASS_EN).                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_issue_station;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush, in_valid, in_ready;
    logic [7:0]    in_op_spec, alu_op_spec;
    logic [DW-1:0] in_lhs, in_rhs, cdb_data, alu_lhs, alu_rhs;
    logic          in_lhs_valid, in_rhs_valid, cdb_valid;
    logic [TW-1:0] in_lhs_tag, in_rhs_tag, in_dst_tag, cdb_tag, alu_dst_tag;
    logic          issue_valid, issue_ready, alu_lhs_valid, alu_rhs_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_station #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op_spec(in_op_spec),
        .in_lhs(in_lhs), .in_rhs(in_rhs),
        .in_lhs_valid(in_lhs_valid), .in_rhs_valid(in_rhs_valid),
        .in_lhs_tag(in_lhs_tag), .in_rhs_tag(in_rhs_tag), .in_dst_tag(in_dst_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_lhs_valid(alu_lhs_valid), .alu_rhs_valid(alu_rhs_valid),
        .alu_op_spec(alu_op_spec), .alu_dst_tag(alu_dst_tag)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an age-ordered queue of pending operations plus the ALU output slot.
    typedef struct {
        logic [7:0]    op;
        logic [DW-1:0] lhs, rhs;
        bit            lv, rv;
        logic [TW-1:0] lt, rt, dst;
    } ent_t;

    ent_t          mq[$];
    bit            m_iv = 1'b0;
    logic [DW-1:0] m_lhs = '0, m_rhs = '0;
    logic [7:0]    m_op = '0;
    logic [TW-1:0] m_dst = '0;

    task automatic take(input ent_t e);
        m_iv = 1'b1; m_lhs = e.lhs; m_rhs = e.rhs; m_op = e.op; m_dst = e.dst;
    endtask

    task automatic model_step();
        ent_t e, ne;
        bit   acc, ne_elig, ok;
        int   pick;
        if (!rst_n) begin
            mq.delete();
            m_iv = 1'b0; m_lhs = '0; m_rhs = '0; m_op = '0; m_dst = '0;
        end else if (flush) begin
            mq.delete();
            m_iv = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            ne.op = in_op_spec; ne.dst = in_dst_tag;
            ne.lhs = in_lhs; ne.lv = in_lhs_valid; ne.lt = in_lhs_tag;
            ne.rhs = in_rhs; ne.rv = in_rhs_valid; ne.rt = in_rhs_tag;
            ne_elig = in_lhs_valid && in_rhs_valid;
            if (cdb_valid && !ne.lv && ne.lt == cdb_tag) begin ne.lv = 1'b1; ne.lhs = cdb_data; end
            if (cdb_valid && !ne.rv && ne.rt == cdb_tag) begin ne.rv = 1'b1; ne.rhs = cdb_data; end
`ifdef ALU_ISSUE_BYPASS_EN
            ne_elig = ne.lv && ne.rv;
`endif
            pick = -1;
            for (int i = 0; i < mq.size(); i++) begin
                e  = mq[i];
                ok = e.lv && e.rv;
                if (cdb_valid && !e.lv && e.lt == cdb_tag) begin e.lv = 1'b1; e.lhs = cdb_data; end
                if (cdb_valid && !e.rv && e.rt == cdb_tag) begin e.rv = 1'b1; e.rhs = cdb_data; end
`ifdef ALU_ISSUE_BYPASS_EN
                ok = e.lv && e.rv;
`endif
                mq[i] = e;
                if (pick < 0 && ok) pick = i;
            end
            if (!m_iv || issue_ready) begin
                if (pick >= 0) begin
                    take(mq[pick]);
                    mq.delete(pick);
                    if (acc) mq.push_back(ne);
                end else if (acc && ne_elig) begin
                    take(ne);
                end else begin
                    m_iv = 1'b0;
                    if (acc) mq.push_back(ne);
                end
            end else if (acc) begin
                mq.push_back(ne);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("issue_valid", issue_valid, m_iv);
        chk("alu_lhs_valid", alu_lhs_valid, m_iv);
        chk("alu_rhs_valid", alu_rhs_valid, m_iv);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        if (m_iv || !rst_n) begin
            chk("alu_lhs", alu_lhs, m_lhs);
            chk("alu_rhs", alu_rhs, m_rhs);
            chk("alu_op_spec", alu_op_spec, m_op);
            chk("alu_dst_tag", alu_dst_tag, m_dst);
        end
    end

    task automatic idle();
        in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
        in_lhs_valid = 1'b0; in_rhs_valid = 1'b0;
    endtask

    task automatic alloc(input logic [7:0] op, input logic [DW-1:0] l, input logic lv,
                         input logic [TW-1:0] lt, input logic [DW-1:0] r, input logic rv,
                         input logic [TW-1:0] rt, input logic [TW-1:0] d);
        in_valid = 1'b1; in_op_spec = op; in_dst_tag = d;
        in_lhs = l; in_lhs_valid = lv; in_lhs_tag = lt;
        in_rhs = r; in_rhs_valid = rv; in_rhs_tag = rt;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        issue_ready = 1'b1;
        in_op_spec = '0; in_lhs = '0; in_rhs = '0; in_lhs_tag = '0; in_rhs_tag = '0;
        in_dst_tag = '0; cdb_tag = '0; cdb_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", in_ready, 1);
        chk("post-reset issue_valid", issue_valid, 0);

        // ADD 5 + 7, both operands present: issues the next cycle
        alloc(8'h01, 5, 1, 0, 7, 1, 0, 4'h9); step();
        chk("add issue_valid", issue_valid, 1);
        chk("add alu_lhs", alu_lhs, 5);
        chk("add alu_rhs", alu_rhs, 7);
        chk("add dst", alu_dst_tag, 4'h9);
        chk("add op", alu_op_spec, 8'h01);
        step();
        chk("add drained", issue_valid, 0);

        // Fill all four slots waiting on tag 3, then wake them together
        for (int k = 0; k < 4; k++) begin
            alloc(8'h02, 0, 0, 3, 64'(16 + k), 1, 0, 4'(k)); step();
        end
        chk("full in_ready", in_ready, 0);
        chk("full issue_valid", issue_valid, 0);
        cdb(3, 64'hAA); step();
`ifndef ALU_ISSUE_BYPASS_EN
        chk("wake no-bypass latency", issue_valid, 0);
        step();
`endif
        for (int k = 0; k < 4; k++) begin
            chk("burst issue_valid", issue_valid, 1);
            chk("burst alu_lhs", alu_lhs, 64'hAA);
            chk("burst dst", alu_dst_tag, 4'(k));
            step();
        end
        chk("burst drained", issue_valid, 0);

        // Younger ready op overtakes an older one waiting on tag 2
        alloc(8'h03, 0, 0, 2, 64'h11, 1, 0, 4'd10); step();
        alloc(8'h04, 64'h21, 1, 0, 64'h22, 1, 0, 4'd11); step();
        chk("overtake dst", alu_dst_tag, 4'd11);
        step();
        chk("older still waiting", issue_valid, 0);
        cdb(2, 64'h55); step();
`ifndef ALU_ISSUE_BYPASS_EN
        chk("tag2 N+1 idle", issue_valid, 0);
        step();
`endif
        chk("tag2 issue_valid", issue_valid, 1);
        chk("tag2 dst", alu_dst_tag, 4'd10);
        chk("tag2 alu_lhs", alu_lhs, 64'h55);
        step();

        // Back-pressure: outputs hold while issue_ready is low
        issue_ready = 1'b0;
        alloc(8'h05, 64'h100, 1, 0, 64'h200, 1, 0, 4'd1); step();
        alloc(8'h06, 64'h300, 1, 0, 64'h400, 1, 0, 4'd2); step();
        for (int k = 0; k < 3; k++) begin
            chk("stall dst", alu_dst_tag, 4'd1);
            chk("stall alu_lhs", alu_lhs, 64'h100);
            step();
        end
        issue_ready = 1'b1; step();
        chk("after stall dst", alu_dst_tag, 4'd2);
        chk("after stall alu_rhs", alu_rhs, 64'h400);
        step();

        // Operand captured on its allocating cycle; unmatched tags are ignored
        alloc(8'h07, 0, 0, 7, 64'h1, 1, 0, 4'd4); cdb(7, 64'h77); step();
`ifndef ALU_ISSUE_BYPASS_EN
        chk("alloc-capture N+1 idle", issue_valid, 0);
        step();
`endif
        chk("alloc-capture alu_lhs", alu_lhs, 64'h77);
        step();
        alloc(8'h08, 0, 0, 6, 64'h1, 1, 0, 4'd5); step();
        cdb(4'hF, 64'h99); step(); step();
        chk("unmatched tag", issue_valid, 0);
        cdb(6, 64'h66); step(); step(); step();

        // Flush with concurrent allocate and broadcast at count=2
        issue_ready = 1'b0;
        alloc(8'h09, 1, 1, 0, 2, 1, 0, 4'd6); step();
        alloc(8'h0A, 0, 0, 6, 3, 1, 0, 4'd7); step();
        alloc(8'h0B, 0, 0, 6, 4, 1, 0, 4'd8); step();
        chk("pre-flush issue_valid", issue_valid, 1);
        flush = 1'b1; alloc(8'h0C, 5, 1, 0, 6, 1, 0, 4'd9); cdb(6, 64'h66); step();
        chk("flush issue_valid", issue_valid, 0);
        chk("flush in_ready", in_ready, 1);
        issue_ready = 1'b1;
        cdb(6, 64'h66); step(); step();
        chk("flush emptied", issue_valid, 0);

        // Asynchronous reset mid-operation
        issue_ready = 1'b0;
        alloc(8'h0D, 64'h12, 1, 0, 64'h34, 1, 0, 4'd3); step();
        alloc(8'h0E, 0, 0, 9, 64'h5, 1, 0, 4'd2); step();
        rst_n = 1'b0;
        #1;
        chk("async rst issue_valid", issue_valid, 0);
        chk("async rst alu_lhs", alu_lhs, 0);
        chk("async rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; issue_ready = 1'b1;
        @(negedge clk);
        chk("post mid-reset in_ready", in_ready, 1);
        cdb(9, 64'h9); step(); step();
        chk("entries discarded", issue_valid, 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
